// File: rtl/ws2812_pkg.sv
// Shared constants and FSM state type for the WS2812 strip driver and pixel receiver.
package ws2812_pkg;

  localparam int GRB_W        = 24;
  localparam int T0H_CYC      = 18;
  localparam int T1H_CYC      = 35;
  localparam int BIT_CYC      = 63;
  localparam int THRESH_CYC   = 27;
  localparam int MAX_HIGH_CYC = 60;
  localparam int RESET_CYC    = 2500;
  localparam int MIN_HIGH_CYC = 5;

  typedef enum logic [1:0] {
    WAIT_GAP = 2'd0,
    ARMED    = 2'd1,
    CAPTURE  = 2'd2,
    PASS     = 2'd3
  } rx_state_e;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ws2812_pixel_rx_if.sv
// Decoded-pixel result bus: master is the receiver, slave is whoever consumes the colour.
interface ws2812_pixel_rx_if;
  import ws2812_pkg::*;

  logic [GRB_W-1:0] grb;
  logic             valid;
  logic             frame_done;
  logic             err;

  modport master (output grb, output valid, output frame_done, output err);
  modport slave  (input  grb, input  valid, input  frame_done, input  err);

endinterface

// File: rtl/ws2812_pixel_rx_edge_sync.sv
// Input synchroniser, edge pulses and saturating high/low run-length counters for the WS2812 line.
module ws_edge_sync
  import ws2812_pkg::*;
#(
  parameter int MAX_HIGH_CYC = 60,
  parameter int RESET_CYC    = 2500,
  parameter int MIN_HIGH_CYC = 5,
  parameter bit GLITCH_EN    = 1'b0,
  parameter int HCNT_W       = 6,
  parameter int LCNT_W       = 12
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              din_i,
  output logic              din_s_o,
  output logic              rise_o,
  output logic              fall_o,
  output logic [HCNT_W-1:0] hcnt_o,
  output logic [LCNT_W-1:0] lcnt_o
);

  logic              meta_q;
  logic              din_s_q;
  logic              prev_q;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;

  // A too-short high pulse leaves the low counter untouched when glitch filtering is on.
  always_comb begin
    hcnt_d = hcnt_q;
    lcnt_d = lcnt_q;
    if (din_s_q) begin
      if (hcnt_q < HCNT_W'(MAX_HIGH_CYC + 1)) begin
        hcnt_d = hcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q;
      end
      if (GLITCH_EN && (hcnt_q < HCNT_W'(MIN_HIGH_CYC - 1))) begin
        lcnt_d = lcnt_q;
      end else begin
        lcnt_d = '0;
      end
    end else begin
      hcnt_d = '0;
      if (lcnt_q < LCNT_W'(RESET_CYC)) begin
        lcnt_d = lcnt_q + 1'b1;
      end else begin
        lcnt_d = lcnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      meta_q  <= 1'b0;
      din_s_q <= 1'b0;
      prev_q  <= 1'b0;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      meta_q  <= din_i;
      din_s_q <= meta_q;
      prev_q  <= din_s_q;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

  assign din_s_o = din_s_q;
  assign rise_o  = din_s_q & ~prev_q;
  assign fall_o  = ~din_s_q & prev_q;
  assign hcnt_o  = hcnt_q;
  assign lcnt_o  = lcnt_q;

endmodule

// File: rtl/ws2812_pixel_rx.sv
// WS2812 pixel receiver: latches the first GRB word of each frame and forwards the rest on dout.
// Optional glitch filter (ignore short highs while capturing): define WS2812_RX_GLITCH_FILTER_EN.
module ws2812_pixel_rx #(
  parameter int THRESH_CYC   = ws2812_pkg::THRESH_CYC,
  parameter int MAX_HIGH_CYC = ws2812_pkg::MAX_HIGH_CYC,
  parameter int RESET_CYC    = ws2812_pkg::RESET_CYC,
  parameter int MIN_HIGH_CYC = ws2812_pkg::MIN_HIGH_CYC
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      din,
  output logic                      dout,
  ws2812_pixel_rx_if.master         bus
);
  import ws2812_pkg::*;

`ifdef WS2812_RX_GLITCH_FILTER_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  localparam int HCNT_W = cnt_width(MAX_HIGH_CYC + 1);
  localparam int LCNT_W = cnt_width(RESET_CYC);

  logic              din_s, rise_s, fall_s;
  logic [HCNT_W-1:0] hcnt_s;
  logic [LCNT_W-1:0] lcnt_s;

  ws_edge_sync #(
    .MAX_HIGH_CYC (MAX_HIGH_CYC),
    .RESET_CYC    (RESET_CYC),
    .MIN_HIGH_CYC (MIN_HIGH_CYC),
    .GLITCH_EN    (GLITCH_EN),
    .HCNT_W       (HCNT_W),
    .LCNT_W       (LCNT_W)
  ) u_sync (
    .clk     (clk),
    .clr     (clr),
    .din_i   (din),
    .din_s_o (din_s),
    .rise_o  (rise_s),
    .fall_o  (fall_s),
    .hcnt_o  (hcnt_s),
    .lcnt_o  (lcnt_s)
  );

  rx_state_e        state_q;
  logic [GRB_W-1:0] shift_q, shift_d;
  logic [4:0]       idx_q;
  logic [GRB_W-1:0] grb_q;
  logic             valid_q, frame_done_q, err_q, pass_q;
  logic             bit_s, gap_s, long_s, glitch_s;

  // The gap is qualified with a low line so a held-over low count never fires during a high.
  always_comb begin
    bit_s    = (hcnt_s >= HCNT_W'(THRESH_CYC));
    long_s   = (hcnt_s > HCNT_W'(MAX_HIGH_CYC));
    gap_s    = (lcnt_s == LCNT_W'(RESET_CYC)) && !din_s;
    glitch_s = GLITCH_EN && (hcnt_s < HCNT_W'(MIN_HIGH_CYC));
    shift_d  = {shift_q[GRB_W-2:0], bit_s};
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= WAIT_GAP;
      shift_q      <= '0;
      idx_q        <= 5'd0;
      grb_q        <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        WAIT_GAP: begin
          if (gap_s) state_q <= ARMED;
        end
        ARMED: begin
          idx_q  <= 5'd0;
          pass_q <= 1'b0;
          if (rise_s) state_q <= CAPTURE;
        end
        CAPTURE: begin
          if (long_s) begin
            err_q   <= 1'b1;
            state_q <= WAIT_GAP;
          end else if (fall_s && !glitch_s) begin
            shift_q <= shift_d;
            idx_q   <= idx_q + 5'd1;
            if (idx_q == 5'd23) begin
              grb_q   <= shift_d;
              valid_q <= 1'b1;
              pass_q  <= 1'b1;
              state_q <= PASS;
            end
          end else if (gap_s) begin
            // A gap with no decoded bits is just an idle line, not a truncated frame.
            if (idx_q != 5'd0) begin
              err_q        <= 1'b1;
              frame_done_q <= 1'b1;
            end
            state_q <= ARMED;
          end
        end
        PASS: begin
          if (gap_s) begin
            frame_done_q <= 1'b1;
            pass_q       <= 1'b0;
            state_q      <= ARMED;
          end
        end
        default: begin
          state_q <= WAIT_GAP;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout           = din_s & pass_q;
  assign bus.grb        = grb_q;
  assign bus.valid      = valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_ws2812_pixel_rx.sv
// Self-checking bench for ws2812_pixel_rx: directed and random pulse trains against a pulse-width model.
module tb_ws2812_pixel_rx;

  localparam int TH   = 27;
  localparam int MAXH = 60;
  localparam int RST  = 2500;
  localparam int MINH = 5;
  localparam int GAP  = RST + 20;
`ifdef WS2812_RX_GLITCH_FILTER_EN
  localparam bit GF = 1'b1;
`else
  localparam bit GF = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic din = 1'b0;
  logic dout_a, dout_b;

  ws2812_pixel_rx_if bus_a ();
  ws2812_pixel_rx_if bus_b ();

  ws2812_pixel_rx dut_a (.clk(clk), .clr(clr), .din(din),    .dout(dout_a), .bus(bus_a));
  ws2812_pixel_rx dut_b (.clk(clk), .clr(clr), .din(dout_a), .dout(dout_b), .bus(bus_b));

  always #5 clk = ~clk;

  // Output monitor: pulse counters, event times, forwarded pulse widths, forwarding delay.
  int cyc = 0, n_valid = 0, n_fd = 0, n_err = 0, n_errfd = 0, n_vfd = 0, n_late = 0;
  int v_cyc = 0, fd_cyc = 0, run = 0;
  logic [1:0] din_hist = 2'b00;
  int got_fwd[$];

  always @(negedge clk) begin
    cyc++;
    if (bus_a.valid) begin n_valid++; v_cyc = cyc; end
    if (bus_a.frame_done) begin n_fd++; fd_cyc = cyc; end
    if (bus_a.err) n_err++;
    if (bus_a.err && bus_a.frame_done) n_errfd++;
    if (bus_a.valid && bus_a.frame_done) n_vfd++;
    if (dout_a && !din_hist[1]) n_late++;
    if (dout_a) run++;
    else if (run > 0) begin got_fwd.push_back(run); run = 0; end
    din_hist = {din_hist[0], din};
  end

  int n_chk = 0, n_fail = 0;
  int exp_valid = 0, exp_fd = 0, exp_err = 0, exp_errfd = 0;
  logic [23:0] exp_grb = 24'h000000;
  int exp_fwd[$];
  int hq[$], lq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      din = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add_bit(input logic b);
    hq.push_back(b ? 35 : 18);
    lq.push_back(b ? 28 : 45);
  endtask

  task automatic add_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) add_bit(w[i]);
  endtask

  // Reference: walk the high-pulse widths of one frame and predict pulses, colour and forwarded widths.
  task automatic model();
    int n = 0;
    bit passing = 1'b0;
    bit aborted = 1'b0;
    logic [23:0] acc = 24'h000000;
    exp_fwd.delete();
    foreach (hq[i]) begin
      if (aborted) continue;
      if (passing) begin exp_fwd.push_back(hq[i]); continue; end
      if (hq[i] > MAXH) begin
        exp_err++;
        aborted = 1'b1;
      end else if (!(GF && hq[i] < MINH)) begin
        acc = {acc[22:0], (hq[i] >= TH)};
        n++;
        if (n == 24) begin exp_valid++; exp_grb = acc; passing = 1'b1; end
      end
    end
    if (passing) exp_fd++;
    else if (!aborted && n > 0) begin exp_err++; exp_fd++; exp_errfd++; end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_valid"}, 32'(n_valid), 32'(exp_valid));
    chk({tag, "_fdone"}, 32'(n_fd), 32'(exp_fd));
    chk({tag, "_err"}, 32'(n_err), 32'(exp_err));
    chk({tag, "_errfd"}, 32'(n_errfd), 32'(exp_errfd));
    chk({tag, "_grb"}, 32'(bus_a.grb), 32'(exp_grb));
  endtask

  task automatic play(input string tag);
    model();
    got_fwd.delete();
    foreach (hq[i]) begin
      drive(1'b1, hq[i]);
      drive(1'b0, lq[i]);
    end
    drive(1'b0, GAP);
    check_counts(tag);
    chk({tag, "_fwd_n"}, 32'(got_fwd.size()), 32'(exp_fwd.size()));
    for (int i = 0; i < exp_fwd.size() && i < got_fwd.size(); i++)
      chk({tag, "_fwd_w"}, 32'(got_fwd[i]), 32'(exp_fwd[i]));
    chk({tag, "_fwd_delay"}, 32'(n_late), 32'd0);
    hq.delete();
    lq.delete();
  endtask

  initial begin
    int d;
    int nb;
    clr = 1'b0;
    din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grb", 32'(bus_a.grb), 32'd0);
    chk("rst_valid", 32'(bus_a.valid), 32'd0);
    chk("rst_fdone", 32'(bus_a.frame_done), 32'd0);
    chk("rst_err", 32'(bus_a.err), 32'd0);
    chk("rst_dout", 32'(dout_a), 32'd0);
    clr = 1'b1;
    drive(1'b0, GAP);

    add_word(24'h123456);
    play("t1");
    d = fd_cyc - v_cyc;
    chk("t1_fd_delay", 32'(d >= RST && d <= RST + 1), 32'd1);

    add_word(24'hFF0000);
    add_word(24'h00FF00);
    play("t2");
    chk("t2_b_grb", 32'(bus_b.grb), 32'h0000FF00);

    add_word(24'hC3C3C3);
    hq[5] = 61;
    add_word(24'h0F0F0F);
    play("t3");
    add_word(24'h5A5A5A);
    play("t3b");

    for (int i = 0; i < 10; i++) add_bit(i[0]);
    play("t4");

    add_word(24'h777777);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, hq[i]);
      drive(1'b0, lq[i]);
    end
    drive(1'b1, 10);
    clr = 1'b0;
    drive(1'b1, 1);
    clr = 1'b1;
    chk("t5_rst_grb", 32'(bus_a.grb), 32'd0);
    chk("t5_rst_valid", 32'(bus_a.valid), 32'd0);
    chk("t5_rst_fdone", 32'(bus_a.frame_done), 32'd0);
    chk("t5_rst_err", 32'(bus_a.err), 32'd0);
    chk("t5_rst_dout", 32'(dout_a), 32'd0);
    exp_grb = 24'h000000;
    drive(1'b1, hq[12] - 11);
    drive(1'b0, lq[12]);
    for (int i = 13; i < 24; i++) begin
      drive(1'b1, hq[i]);
      drive(1'b0, lq[i]);
    end
    drive(1'b0, GAP);
    hq.delete();
    lq.delete();
    check_counts("t5");
    add_word(24'h9E3779);
    play("t5b");

    add_word(24'hA5A5A5);
    hq.insert(8, 3);
    lq.insert(8, lq[7] - 13);
    lq[7] = 10;
    play("t6");
    chk("t6_grb_const", 32'(bus_a.grb), GF ? 32'h00A5A5A5 : 32'h00A552D2);

    for (int k = 0; k < 4; k++) begin
      nb = $urandom_range(10, 32);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 1) == 1) hq.push_back($urandom_range(30, 55));
        else hq.push_back($urandom_range(8, 24));
        lq.push_back($urandom_range(20, 50));
      end
      play("rnd");
    end

    chk("valid_fdone_overlap", 32'(n_vfd), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
